// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction-fetch unit.
//   state_t      - fetch FSM states (ST_AR, ST_R, ST_OUT)
//   NOP_INS      - instruction presented at reset and in place of faulting fetches
//   RESP_OKAY    - AXI OKAY response code
//   DEF_RESET_PC - default reset PC
package ifu_pkg;

    typedef enum logic [1:0] {
        ST_AR  = 2'd0,
        ST_R   = 2'd1,
        ST_OUT = 2'd2
    } state_t;

    localparam logic [31:0] NOP_INS      = 32'h0000_0013;
    localparam logic [1:0]  RESP_OKAY    = 2'b00;
    localparam logic [31:0] DEF_RESET_PC = 32'h3000_0000;

endpackage

// File: rtl/ifu_if.sv
// ifu_if: bundles the AXI4-Lite read channels and the decode-side handshake.
//   master - fetch unit side (drives AR/R ready and the decode outputs)
//   slave  - memory / decode side
interface ifu_if #(
    parameter int ADDR_W = 32
);
    logic              arvalid;
    logic [ADDR_W-1:0] araddr;
    logic              arready;
    logic              rvalid;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rready;
    logic              o_valid;
    logic              i_ready;
    logic [ADDR_W-1:0] o_pc;
    logic [31:0]       o_ins;
    logic              o_acc_fault;

    modport master (
        output arvalid, araddr, rready, o_valid, o_pc, o_ins, o_acc_fault,
        input  arready, rvalid, rdata, rresp, i_ready
    );

    modport slave (
        input  arvalid, araddr, rready, o_valid, o_pc, o_ins, o_acc_fault,
        output arready, rvalid, rdata, rresp, i_ready
    );
endinterface

// File: rtl/ifu_pc_gen.sv
// ifu_pc_gen: program counter and discard flag for the fetch unit.
//   clock, reset      - core clock, async active-low reset
//   redirect_valid/pc - redirect request (takes priority over advance)
//   advance           - instruction accepted by decode, step pc by 4
//   set_discard       - an in-flight response must be dropped
//   clr_discard       - a response has been consumed
//   pc, pc_inc        - current pc and pc+4 (wraps modulo 2^ADDR_W)
//   discard           - next read response is stale
module ifu_pc_gen
    import ifu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              advance,
    input  logic              set_discard,
    input  logic              clr_discard,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_inc,
    output logic              discard
);

    assign pc_inc = pc + ADDR_W'(4);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc      <= RESET_PC;
            discard <= 1'b0;
        end else begin
            if (redirect_valid)
                pc <= redirect_pc;
            else if (advance)
                pc <= pc_inc;

            if (set_discard)
                discard <= 1'b1;
            else if (clr_discard)
                discard <= 1'b0;
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction-fetch stage. Issues single-beat AXI4-Lite reads at pc
// and hands {pc, instruction} to decode over a valid/ready handshake.
//   clock, reset            - core clock, async active-low reset
//   redirect_valid/pc       - one-cycle pc redirect from downstream
//   halt                    - level, blocks new read requests
//   bus (ifu_if.master)     - AXI read channels and decode outputs
//   o_misalign              - only with IFU_MISALIGN_EXCPT_EN: misaligned pc fault
// Optional feature macro: IFU_MISALIGN_EXCPT_EN. When undefined, araddr is
// word-aligned and misaligned pcs are fetched silently.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
`ifdef IFU_MISALIGN_EXCPT_EN
    output logic              o_misalign,
`endif
    ifu_if.master             bus
);

    state_t            state;
    logic              arvalid_q;
    logic [ADDR_W-1:0] araddr_q;
    logic              rready_q;
    logic              o_valid_q;
    logic [ADDR_W-1:0] o_pc_q;
    logic [31:0]       o_ins_q;
    logic              o_acc_fault_q;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_inc;
    logic              discard;
    logic              advance;
    logic              set_discard;
    logic              clr_discard;

    // A redirect that catches a request already committed on the bus (pending
    // AR or outstanding R) cannot be cancelled, so its response gets dropped.
    assign set_discard = redirect_valid &&
                         ((state == ST_AR && arvalid_q) || (state == ST_R && !bus.rvalid));
    assign clr_discard = (state == ST_R) && bus.rvalid;
    assign advance     = (state == ST_OUT) && o_valid_q && bus.i_ready && !redirect_valid;

    ifu_pc_gen #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clock          (clock),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .advance        (advance),
        .set_discard    (set_discard),
        .clr_discard    (clr_discard),
        .pc             (pc),
        .pc_inc         (pc_inc),
        .discard        (discard)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= ST_AR;
            arvalid_q     <= 1'b0;
            araddr_q      <= RESET_PC;
            rready_q      <= 1'b0;
            o_valid_q     <= 1'b0;
            o_pc_q        <= RESET_PC;
            o_ins_q       <= NOP_INS;
            o_acc_fault_q <= 1'b0;
`ifdef IFU_MISALIGN_EXCPT_EN
            o_misalign    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_AR: begin
                    if (arvalid_q) begin
                        // araddr is held even across a redirect until accepted
                        if (bus.arready) begin
                            arvalid_q <= 1'b0;
                            rready_q  <= 1'b1;
                            state     <= ST_R;
                        end
                    end else if (!redirect_valid && !halt) begin
`ifdef IFU_MISALIGN_EXCPT_EN
                        if (pc[1:0] != 2'b00) begin
                            o_valid_q     <= 1'b1;
                            o_pc_q        <= pc;
                            o_ins_q       <= NOP_INS;
                            o_acc_fault_q <= 1'b1;
                            o_misalign    <= 1'b1;
                            state         <= ST_OUT;
                        end else begin
                            arvalid_q <= 1'b1;
                            araddr_q  <= pc;
                        end
`else
                        arvalid_q <= 1'b1;
                        araddr_q  <= {pc[ADDR_W-1:2], 2'b00};
`endif
                    end
                end
                ST_R: begin
                    if (bus.rvalid) begin
                        rready_q <= 1'b0;
                        state    <= ST_AR;
                        if (!discard && !redirect_valid) begin
                            o_valid_q     <= 1'b1;
                            o_pc_q        <= pc;
                            o_ins_q       <= (bus.rresp == RESP_OKAY) ? bus.rdata : NOP_INS;
                            o_acc_fault_q <= (bus.rresp != RESP_OKAY);
`ifdef IFU_MISALIGN_EXCPT_EN
                            o_misalign    <= 1'b0;
`endif
                            state         <= ST_OUT;
                        end
                    end
                end
                ST_OUT: begin
                    if (redirect_valid || bus.i_ready) begin
                        o_valid_q <= 1'b0;
                        state     <= ST_AR;
                    end
                    // Issue the next request straight away to reach one
                    // instruction every three cycles; pc+4 keeps pc alignment.
                    if (advance && !halt) begin
                        arvalid_q <= 1'b1;
`ifdef IFU_MISALIGN_EXCPT_EN
                        araddr_q  <= pc_inc;
`else
                        araddr_q  <= {pc_inc[ADDR_W-1:2], 2'b00};
`endif
                    end
                end
                default: state <= ST_AR;
            endcase
        end
    end

    assign bus.arvalid     = arvalid_q;
    assign bus.araddr      = araddr_q;
    assign bus.rready      = rready_q;
    assign bus.o_valid     = o_valid_q;
    assign bus.o_pc        = o_pc_q;
    assign bus.o_ins       = o_ins_q;
    assign bus.o_acc_fault = o_acc_fault_q;

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;
    import ifu_pkg::*;

    logic        clock;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
`ifdef IFU_MISALIGN_EXCPT_EN
    logic        o_misalign;
`endif
    int          n_checks;
    int          n_errors;

    ifu_if #(.ADDR_W(32)) bus ();

    ifu_fetch #(.ADDR_W(32), .RESET_PC(32'h3000_0000)) dut (
        .clock          (clock),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
`ifdef IFU_MISALIGN_EXCPT_EN
        .o_misalign     (o_misalign),
`endif
        .bus            (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Bounded wait (from a negedge) for arvalid, then check the address.
    task automatic wait_ar(input string tag, input logic [31:0] exp);
        int i;
        i = 0;
        while (!bus.arvalid && i < 20) begin
            @(negedge clock);
            i++;
        end
        check({tag, "_arvalid"}, 32'(bus.arvalid), 32'd1);
        check(tag, bus.araddr, exp);
    endtask

    // Called at a negedge with an accepted AR pending; returns one beat one
    // cycle after the handshake and comes back at the negedge after it.
    task automatic serve(input logic [31:0] data, input logic [1:0] resp);
        @(negedge clock);
        bus.rvalid = 1'b1;
        bus.rdata  = data;
        bus.rresp  = resp;
        @(negedge clock);
        bus.rvalid = 1'b0;
        bus.rdata  = 32'h0;
        bus.rresp  = 2'b00;
    endtask

    task automatic accept();
        bus.i_ready = 1'b1;
        @(negedge clock);
        bus.i_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] hold_pc;
        logic [31:0] hold_ins;
        n_checks       = 0;
        n_errors       = 0;
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt           = 1'b0;
        bus.arready    = 1'b0;
        bus.rvalid     = 1'b0;
        bus.rdata      = 32'h0;
        bus.rresp      = 2'b00;
        bus.i_ready    = 1'b0;
        repeat (3) @(negedge clock);

        check("rst_arvalid", 32'(bus.arvalid), 32'd0);
        check("rst_rready",  32'(bus.rready),  32'd0);
        check("rst_o_valid", 32'(bus.o_valid), 32'd0);
        check("rst_o_ins",   bus.o_ins,        32'h0000_0013);
        check("rst_o_pc",    bus.o_pc,         32'h3000_0000);
        check("rst_fault",   32'(bus.o_acc_fault), 32'd0);

        reset       = 1'b1;
        bus.arready = 1'b1;

        // basic fetch
        wait_ar("t1_araddr", 32'h3000_0000);
        serve(32'h0000_0413, 2'b00);
        check("t1_o_valid", 32'(bus.o_valid), 32'd1);
        check("t1_o_ins",   bus.o_ins,        32'h0000_0413);
        check("t1_o_pc",    bus.o_pc,         32'h3000_0000);
        check("t1_fault",   32'(bus.o_acc_fault), 32'd0);

        // decode stall
        hold_pc  = bus.o_pc;
        hold_ins = bus.o_ins;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check("t2_hold_valid", 32'(bus.o_valid), 32'd1);
            check("t2_hold_pc",    bus.o_pc,  hold_pc);
            check("t2_hold_ins",   bus.o_ins, hold_ins);
            check("t2_no_ar",      32'(bus.arvalid), 32'd0);
        end
        accept();
        check("t2_valid_drop", 32'(bus.o_valid), 32'd0);
        wait_ar("t2_araddr", 32'h3000_0004);
        serve(32'h0010_0093, 2'b00);
        check("t2_o_pc",  bus.o_pc,  32'h3000_0004);
        check("t2_o_ins", bus.o_ins, 32'h0010_0093);
        accept();

        // redirect while in R
        wait_ar("t3_araddr_old", 32'h3000_0008);
        @(negedge clock);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3000_0100;
        @(negedge clock);
        redirect_valid = 1'b0;
        bus.rvalid     = 1'b1;
        bus.rdata      = 32'h0BAD_0BAD;
        @(negedge clock);
        bus.rvalid     = 1'b0;
        check("t3_dropped", 32'(bus.o_valid), 32'd0);
        wait_ar("t3_araddr_new", 32'h3000_0100);
        serve(32'h0020_0113, 2'b00);
        check("t3_o_pc",  bus.o_pc,  32'h3000_0100);
        check("t3_o_ins", bus.o_ins, 32'h0020_0113);

        // redirect with AR pending and arready low
        bus.arready = 1'b0;
        accept();
        wait_ar("t4_araddr_old", 32'h3000_0104);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3000_0200;
        @(negedge clock);
        redirect_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("t4_hold_arvalid", 32'(bus.arvalid), 32'd1);
            check("t4_hold_araddr",  bus.araddr, 32'h3000_0104);
            @(negedge clock);
        end
        bus.arready = 1'b1;
        @(negedge clock);
        bus.rvalid  = 1'b1;
        bus.rdata   = 32'h0BAD_0104;
        @(negedge clock);
        bus.rvalid  = 1'b0;
        check("t4_dropped", 32'(bus.o_valid), 32'd0);
        wait_ar("t4_araddr_new", 32'h3000_0200);

        // error response
        serve(32'hDEAD_BEEF, 2'b10);
        check("t5_o_valid", 32'(bus.o_valid), 32'd1);
        check("t5_fault",   32'(bus.o_acc_fault), 32'd1);
        check("t5_o_ins",   bus.o_ins, 32'h0000_0013);
        check("t5_o_pc",    bus.o_pc,  32'h3000_0200);
        accept();
        wait_ar("t5_araddr", 32'h3000_0204);
        serve(32'h00A0_0513, 2'b00);
        check("t5_fault_clr", 32'(bus.o_acc_fault), 32'd0);
        check("t5_o_ins2",    bus.o_ins, 32'h00A0_0513);

        // redirect while in OUT, then wrap at top of address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        @(negedge clock);
        redirect_valid = 1'b0;
        check("t6_out_redirect", 32'(bus.o_valid), 32'd0);
        wait_ar("t6_araddr_top", 32'hFFFF_FFFC);
        serve(32'h1111_1111, 2'b00);
        check("t6_o_pc_top", bus.o_pc, 32'hFFFF_FFFC);
        accept();
        wait_ar("t6_araddr_wrap", 32'h0000_0000);
        serve(32'h2222_2222, 2'b00);
        check("t6_o_pc_wrap", bus.o_pc, 32'h0000_0000);

        // redirect coincident with decode handshake, then halt
        bus.i_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3000_0300;
        @(negedge clock);
        bus.i_ready    = 1'b0;
        redirect_valid = 1'b0;
        check("t7_delivered", 32'(bus.o_valid), 32'd0);
        halt = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check("t7_halt_no_ar", 32'(bus.arvalid), 32'd0);
        end
        halt = 1'b0;
        wait_ar("t7_araddr", 32'h3000_0300);
        serve(32'h3333_3333, 2'b00);
        check("t7_o_pc", bus.o_pc, 32'h3000_0300);

        // misaligned redirect
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3000_0002;
        @(negedge clock);
        redirect_valid = 1'b0;
`ifdef IFU_MISALIGN_EXCPT_EN
        @(negedge clock);
        check("t8_no_ar",     32'(bus.arvalid), 32'd0);
        check("t8_o_valid",   32'(bus.o_valid), 32'd1);
        check("t8_fault",     32'(bus.o_acc_fault), 32'd1);
        check("t8_misalign",  32'(o_misalign), 32'd1);
        check("t8_o_ins",     bus.o_ins, 32'h0000_0013);
        check("t8_o_pc",      bus.o_pc,  32'h3000_0002);
        accept();
`else
        wait_ar("t8_araddr_aligned", 32'h3000_0000);
        serve(32'h4444_4444, 2'b00);
        check("t8_o_pc",  bus.o_pc, 32'h3000_0002);
        check("t8_fault", 32'(bus.o_acc_fault), 32'd0);
        accept();
`endif

        // reset mid-transaction
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("t9_rst_arvalid", 32'(bus.arvalid), 32'd0);
        check("t9_rst_o_valid", 32'(bus.o_valid), 32'd0);
        check("t9_rst_o_pc",    bus.o_pc, 32'h3000_0000);
        @(negedge clock);
        reset = 1'b1;
        wait_ar("t9_araddr", 32'h3000_0000);
        serve(32'h5555_5555, 2'b00);
        check("t9_o_ins", bus.o_ins, 32'h5555_5555);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
